// File: rtl/cpu_drv_pkg.sv
// Shared types and helpers for the CPU-side request driver.
// The saturating add works on a fixed 32-bit container; callers zero-extend narrower counters.
package cpu_drv_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} drv_state_t;

  typedef struct packed {
    logic timeout;
    logic skip;
  } rsp_flags_t;

  localparam int SAT_W = 32;

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input logic [SAT_W-1:0] max_v);
    logic [SAT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/cpu_drv_chan.sv
// One CPU channel: accepts a command, drives the cache CPU pins, waits for the
// completion edge or a timeout, then releases the pins and pulses a response.
module cpu_drv_chan
  import cpu_drv_pkg::*;
#(
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32,
  parameter int TIMEOUT  = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ena,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic                i_cmd_wr,
  input  logic [ADDR_WID-1:0] i_cmd_addr,
  input  logic [DATA_WID-1:0] i_cmd_data,
  output logic                o_cpu_rd,
  output logic                o_cpu_wr,
  output logic [ADDR_WID-1:0] o_cpu_addr,
  output logic [DATA_WID-1:0] o_cpu_wdata,
  output logic                o_cpu_wdata_oe,
  input  logic [DATA_WID-1:0] i_cpu_rdata,
  input  logic                i_rd_done,
  input  logic                i_wr_done,
  output logic                o_rsp_valid,
  output logic [DATA_WID-1:0] o_rsp_data,
  output rsp_flags_t          o_rsp_flags
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  drv_state_t          r_state;
  logic                r_wr;
  logic [ADDR_WID-1:0] r_addr;
  logic [DATA_WID-1:0] r_data;
  logic [DATA_WID-1:0] r_rdata;
  logic                r_skip;
  logic                r_timeout;
  logic [CW-1:0]       r_cnt;
  logic                r_prev_rd;
  logic                r_prev_wr;
  logic                w_done_edge;

  // Only a low-to-high transition of the selected done line completes a command.
  assign w_done_edge = r_wr ? (i_wr_done & ~r_prev_wr) : (i_rd_done & ~r_prev_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      o_cmd_ready    <= 1'b0;
      o_cpu_rd       <= 1'b0;
      o_cpu_wr       <= 1'b0;
      o_cpu_wdata_oe <= 1'b0;
      o_cpu_addr     <= '0;
      o_cpu_wdata    <= '0;
      o_rsp_valid    <= 1'b0;
      o_rsp_data     <= '0;
      o_rsp_flags    <= '0;
      r_skip         <= 1'b0;
      r_timeout      <= 1'b0;
      r_cnt          <= '0;
      r_prev_rd      <= 1'b0;
      r_prev_wr      <= 1'b0;
    end else begin
      r_prev_rd   <= i_rd_done;
      r_prev_wr   <= i_wr_done;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_rsp_flags <= '0;
      case (r_state)
        IDLE: begin
          o_cmd_ready <= 1'b1;
          if (i_cmd_valid && o_cmd_ready) begin
            r_wr        <= i_cmd_wr;
            r_addr      <= i_cmd_addr;
            r_data      <= i_cmd_data;
            r_rdata     <= '0;
            r_timeout   <= 1'b0;
            r_skip      <= ~i_ena;
            o_cmd_ready <= 1'b0;
            r_state     <= i_ena ? ISSUE : RELEASE;
          end
        end
        ISSUE: begin
          o_cpu_rd       <= ~r_wr;
          o_cpu_wr       <= r_wr;
          o_cpu_addr     <= r_addr;
          o_cpu_wdata    <= r_wr ? r_data : '0;
          o_cpu_wdata_oe <= r_wr;
          r_cnt          <= '0;
          r_state        <= WAIT;
        end
        WAIT: begin
          // A completion edge beats a timeout landing in the same cycle.
          if (w_done_edge) begin
            if (!r_wr) r_rdata <= i_cpu_rdata;
            r_state <= RELEASE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= RELEASE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        RELEASE: begin
          o_cpu_rd       <= 1'b0;
          o_cpu_wr       <= 1'b0;
          o_cpu_wdata_oe <= 1'b0;
          o_cpu_addr     <= '0;
          o_cpu_wdata    <= '0;
          o_rsp_valid    <= 1'b1;
          o_rsp_data     <= r_rdata;
          o_rsp_flags    <= '{timeout: r_timeout, skip: r_skip};
          o_cmd_ready    <= 1'b1;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cpu_req_driver.sv
// N_CPU independent request channels plus saturating aggregate counters.
// This level only packs/unpacks the channel buses and sums the per-cycle responses.
module cpu_req_driver
  import cpu_drv_pkg::*;
#(
  parameter int N_CPU    = 4,
  parameter int ADDR_WID = 32,
  parameter int DATA_WID = 32,
  parameter int TIMEOUT  = 80,
  parameter int CNT_WID  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CPU-1:0]          cpu_ena,
  input  logic [N_CPU-1:0]          cmd_valid,
  output logic [N_CPU-1:0]          cmd_ready,
  input  logic [N_CPU-1:0]          cmd_wr,
  input  logic [N_CPU*ADDR_WID-1:0] cmd_addr,
  input  logic [N_CPU*DATA_WID-1:0] cmd_data,
  output logic [N_CPU-1:0]          cpu_rd,
  output logic [N_CPU-1:0]          cpu_wr,
  output logic [N_CPU*ADDR_WID-1:0] cpu_addr,
  output logic [N_CPU*DATA_WID-1:0] cpu_wdata,
  output logic [N_CPU-1:0]          cpu_wdata_oe,
  input  logic [N_CPU*DATA_WID-1:0] cpu_rdata,
  input  logic [N_CPU-1:0]          data_in_bus_cpu_lv1,
  input  logic [N_CPU-1:0]          cpu_wr_done,
  output logic [N_CPU-1:0]          rsp_valid,
  output logic [N_CPU*DATA_WID-1:0] rsp_data,
  output logic [N_CPU-1:0]          rsp_timeout,
  output logic [N_CPU-1:0]          rsp_skip,
  output logic [CNT_WID-1:0]        txn_cnt,
  output logic [CNT_WID-1:0]        timeout_cnt
);

  localparam logic [SAT_W-1:0] CNT_MAX = SAT_W'((64'd1 << CNT_WID) - 64'd1);

  rsp_flags_t       w_flags [N_CPU];
  logic [SAT_W-1:0] w_txn_inc;
  logic [SAT_W-1:0] w_to_inc;

  for (genvar g = 0; g < N_CPU; g++) begin : g_chan
    cpu_drv_chan #(
      .ADDR_WID(ADDR_WID),
      .DATA_WID(DATA_WID),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .i_ena         (cpu_ena[g]),
      .i_cmd_valid   (cmd_valid[g]),
      .o_cmd_ready   (cmd_ready[g]),
      .i_cmd_wr      (cmd_wr[g]),
      .i_cmd_addr    (cmd_addr[g*ADDR_WID +: ADDR_WID]),
      .i_cmd_data    (cmd_data[g*DATA_WID +: DATA_WID]),
      .o_cpu_rd      (cpu_rd[g]),
      .o_cpu_wr      (cpu_wr[g]),
      .o_cpu_addr    (cpu_addr[g*ADDR_WID +: ADDR_WID]),
      .o_cpu_wdata   (cpu_wdata[g*DATA_WID +: DATA_WID]),
      .o_cpu_wdata_oe(cpu_wdata_oe[g]),
      .i_cpu_rdata   (cpu_rdata[g*DATA_WID +: DATA_WID]),
      .i_rd_done     (data_in_bus_cpu_lv1[g]),
      .i_wr_done     (cpu_wr_done[g]),
      .o_rsp_valid   (rsp_valid[g]),
      .o_rsp_data    (rsp_data[g*DATA_WID +: DATA_WID]),
      .o_rsp_flags   (w_flags[g])
    );
    assign rsp_timeout[g] = w_flags[g].timeout;
    assign rsp_skip[g]    = w_flags[g].skip;
  end

  always_comb begin
    w_txn_inc = '0;
    w_to_inc  = '0;
    for (int i = 0; i < N_CPU; i++) begin
      w_txn_inc = w_txn_inc + SAT_W'(rsp_valid[i] & ~rsp_skip[i]);
      w_to_inc  = w_to_inc + SAT_W'(rsp_valid[i] & rsp_timeout[i]);
    end
  end

  // Counters lag the response pulses by one cycle and stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt     <= '0;
      timeout_cnt <= '0;
    end else begin
      txn_cnt     <= CNT_WID'(sat_add(SAT_W'(txn_cnt), w_txn_inc, CNT_MAX));
      timeout_cnt <= CNT_WID'(sat_add(SAT_W'(timeout_cnt), w_to_inc, CNT_MAX));
    end
  end

endmodule

// File: tb/tb_cpu_req_driver.sv
// Scoreboard bench for cpu_req_driver: per-channel drivers emulate the cache side
// and queue the expected response; a monitor pops and compares on every rsp_valid.
module tb_cpu_req_driver;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 80;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          c_ena [N];
  logic          c_valid [N];
  logic          c_wr [N];
  logic          c_rdd [N];
  logic          c_wrd [N];
  logic [AW-1:0] c_addr [N];
  logic [DW-1:0] c_data [N];
  logic [DW-1:0] c_rdata [N];

  logic [N-1:0]    cpu_ena, cmd_valid, cmd_wr, rd_done, wr_done;
  logic [N*AW-1:0] cmd_addr;
  logic [N*DW-1:0] cmd_data, cpu_rdata;

  always_comb begin
    cpu_ena = '0; cmd_valid = '0; cmd_wr = '0; rd_done = '0; wr_done = '0;
    cmd_addr = '0; cmd_data = '0; cpu_rdata = '0;
    for (int i = 0; i < N; i++) begin
      cpu_ena[i]            = c_ena[i];
      cmd_valid[i]          = c_valid[i];
      cmd_wr[i]             = c_wr[i];
      rd_done[i]            = c_rdd[i];
      wr_done[i]            = c_wrd[i];
      cmd_addr[i*AW +: AW]  = c_addr[i];
      cmd_data[i*DW +: DW]  = c_data[i];
      cpu_rdata[i*DW +: DW] = c_rdata[i];
    end
  end

  logic [N-1:0]    cmd_ready, cpu_rd, cpu_wr, cpu_wdata_oe, rsp_valid, rsp_timeout, rsp_skip;
  logic [N*AW-1:0] cpu_addr;
  logic [N*DW-1:0] cpu_wdata, rsp_data;
  logic [CW-1:0]   txn_cnt, timeout_cnt;

  cpu_req_driver #(.N_CPU(N), .ADDR_WID(AW), .DATA_WID(DW), .TIMEOUT(TO), .CNT_WID(CW)) dut (
    .clk(clk), .rst(rst), .cpu_ena(cpu_ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wdata_oe(cpu_wdata_oe), .cpu_rdata(cpu_rdata),
    .data_in_bus_cpu_lv1(rd_done), .cpu_wr_done(wr_done), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_skip(rsp_skip), .txn_cnt(txn_cnt), .timeout_cnt(timeout_cnt)
  );

  // Narrow-counter instance sharing all stimulus, to exercise saturation.
  logic [N-1:0]    s_cmd_ready, s_cpu_rd, s_cpu_wr, s_oe, s_rsp_valid, s_rsp_timeout, s_rsp_skip;
  logic [N*AW-1:0] s_cpu_addr;
  logic [N*DW-1:0] s_cpu_wdata, s_rsp_data;
  logic [3:0]      s_txn_cnt, s_timeout_cnt;

  cpu_req_driver #(.N_CPU(N), .ADDR_WID(AW), .DATA_WID(DW), .TIMEOUT(TO), .CNT_WID(4)) dut_sat (
    .clk(clk), .rst(rst), .cpu_ena(cpu_ena), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cpu_rd(s_cpu_rd), .cpu_wr(s_cpu_wr),
    .cpu_addr(s_cpu_addr), .cpu_wdata(s_cpu_wdata), .cpu_wdata_oe(s_oe), .cpu_rdata(cpu_rdata),
    .data_in_bus_cpu_lv1(rd_done), .cpu_wr_done(wr_done), .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
    .rsp_timeout(s_rsp_timeout), .rsp_skip(s_rsp_skip), .txn_cnt(s_txn_cnt), .timeout_cnt(s_timeout_cnt)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int ch, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s ch%0d got=%0h expected=%0h (cycle %0d)", nm, ch, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  typedef struct {
    int            ch;
    logic [DW-1:0] data;
    bit            to;
    bit            sk;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  bit   mon_en = 1'b0;
  int   m_txn = 0;
  int   m_to = 0;

  // mode 0: done pulse d cycles after the pins rise; 1: never completes; 2: done already high before issue
  task automatic do_txn(input int ch, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit ena, input int mode, input int d, input logic [DW-1:0] rdat);
    int   t;
    bit   completes;
    bit   got;
    exp_t e;
    for (int k = 0; k < 300 && !cmd_ready[ch]; k++) @(negedge clk);
    if (!cmd_ready[ch]) begin
      chk("ready_wait", ch, 0, 1);
      return;
    end
    c_valid[ch] = 1'b1; c_wr[ch] = wr; c_addr[ch] = addr; c_data[ch] = data;
    c_ena[ch] = ena; c_rdata[ch] = rdat;
    if (mode == 2) begin
      if (wr) c_wrd[ch] = 1'b1; else c_rdd[ch] = 1'b1;
    end
    t = cyc + 1;
    completes = ena && (mode == 0) && (d <= TO - 1);
    e.ch   = ch;
    e.data = (completes && !wr) ? rdat : '0;
    e.to   = ena && !completes;
    e.sk   = !ena;
    e.cyc  = !ena ? t + 1 : (completes ? t + 3 + d : t + 2 + TO);
    sb.push_back(e);
    got = 1'b0;
    for (int k = 0; k < TO + 20; k++) begin
      @(negedge clk);
      if (cyc == t) begin
        c_valid[ch] = 1'b0;
        c_ena[ch] = 1'($urandom);
        chk("ready_low_busy", ch, cmd_ready[ch], 0);
      end
      if (rsp_valid[ch]) begin
        chk("pins_released", ch, {cpu_rd[ch], cpu_wr[ch], cpu_wdata_oe[ch],
            cpu_addr[ch*AW +: AW], cpu_wdata[ch*DW +: DW]}, '0);
        got = 1'b1;
        break;
      end
      if (ena && cyc > t)
        chk("pins_driven", ch, {cpu_rd[ch], cpu_wr[ch], cpu_wdata_oe[ch], cpu_addr[ch*AW +: AW],
            (wr ? cpu_wdata[ch*DW +: DW] : 32'h0)}, {!wr, wr, wr, addr, (wr ? data : 32'h0)});
      else
        chk("pins_idle", ch, {cpu_rd[ch], cpu_wr[ch], cpu_wdata_oe[ch]}, 0);
      if (mode == 0) begin
        if (cyc == t + 1 + d) begin
          if (wr) c_wrd[ch] = 1'b1; else c_rdd[ch] = 1'b1;
        end else begin
          c_wrd[ch] = 1'b0; c_rdd[ch] = 1'b0;
        end
      end
    end
    c_rdd[ch] = 1'b0; c_wrd[ch] = 1'b0; c_rdata[ch] = $urandom;
    if (!got) chk("rsp_wait", ch, 0, 1);
  endtask

  task automatic chan_loop(input int ch);
    int r, mode, d;
    for (int n = 0; n < 25; n++) begin
      r = $urandom_range(19, 0);
      mode = 0;
      d = $urandom_range(9, 0);
      if (r == 14) d = TO - 1;
      else if (r == 15) d = TO;
      else if (r == 16 || r == 17) mode = 1;
      else if (r == 18) mode = 2;
      do_txn(ch, 1'($urandom), $urandom, $urandom, ($urandom_range(7, 0) != 0), mode, d, $urandom);
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin : monitor
    int   idx;
    exp_t e;
    if (mon_en) begin
      chk("txn_cnt", 0, txn_cnt, imin(m_txn, 65535));
      chk("timeout_cnt", 0, timeout_cnt, imin(m_to, 65535));
      chk("txn_cnt_w4", 0, s_txn_cnt, imin(m_txn, 15));
      chk("timeout_cnt_w4", 0, s_timeout_cnt, imin(m_to, 15));
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i]) begin
          idx = -1;
          foreach (sb[j]) if (idx < 0 && sb[j].ch == i) idx = j;
          if (idx < 0) begin
            chk("unexpected_rsp", i, 1, 0);
          end else begin
            e = sb[idx];
            sb.delete(idx);
            chk("rsp_data", i, rsp_data[i*DW +: DW], e.data);
            chk("rsp_timeout", i, rsp_timeout[i], e.to);
            chk("rsp_skip", i, rsp_skip[i], e.sk);
            chk("rsp_cycle", i, cyc, e.cyc);
            m_txn += e.sk ? 0 : 1;
            m_to  += e.to ? 1 : 0;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      c_ena[i] = 1'b1; c_valid[i] = 1'b0; c_wr[i] = 1'b0; c_rdd[i] = 1'b0; c_wrd[i] = 1'b0;
      c_addr[i] = '0; c_data[i] = '0; c_rdata[i] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 0, {cmd_ready, cpu_rd, cpu_wr, cpu_wdata_oe, rsp_valid, rsp_timeout, rsp_skip,
        txn_cnt, timeout_cnt}, '0);
    chk("reset_addr", 0, cpu_addr, '0);
    chk("reset_wdata", 0, cpu_wdata, '0);
    chk("reset_rsp_data", 0, rsp_data, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 0, cmd_ready, 4'hF);
    mon_en = 1'b1;

    do_txn(0, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 0, 6, 32'hDEAD_BEEF);
    do_txn(2, 1'b1, 32'h0000_0100, 32'h1234_5678, 1'b1, 0, 3, 32'h0);
    do_txn(1, 1'b0, 32'h0000_0200, 32'h0, 1'b1, 1, 0, 32'h5555_AAAA);
    do_txn(3, 1'b0, 32'h0000_0300, 32'h0, 1'b0, 0, 2, 32'h7777_7777);
    fork
      do_txn(0, 1'b0, 32'h1000, 32'h0, 1'b1, 0, 4, 32'hA0A0_0000);
      do_txn(1, 1'b0, 32'h2000, 32'h0, 1'b1, 0, 4, 32'hA1A1_1111);
      do_txn(2, 1'b0, 32'h3000, 32'h0, 1'b1, 0, 4, 32'hA2A2_2222);
      do_txn(3, 1'b0, 32'h4000, 32'h0, 1'b1, 0, 4, 32'hA3A3_3333);
    join
    do_txn(0, 1'b0, 32'h0000_0500, 32'h0, 1'b1, 2, 0, 32'hBAD0_BAD0);
    do_txn(1, 1'b1, 32'h0000_0600, 32'hCAFE_F00D, 1'b1, 0, TO - 1, 32'h0);
    do_txn(2, 1'b0, 32'h0000_0700, 32'h0, 1'b1, 0, TO, 32'h1111_2222);
    do_txn(3, 1'b0, 32'h0000_0800, 32'h0, 1'b1, 0, 0, 32'h3333_4444);

    fork
      chan_loop(0);
      chan_loop(1);
      chan_loop(2);
      chan_loop(3);
    join
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 0, sb.size(), 0);
    mon_en = 1'b0;

    // Reset while ch0 sits in WAIT: pins drop, no response for the aborted read.
    chk("ready_before_abort", 0, cmd_ready[0], 1);
    c_valid[0] = 1'b1; c_wr[0] = 1'b0; c_ena[0] = 1'b1; c_addr[0] = 32'h0000_0900;
    @(negedge clk);
    c_valid[0] = 1'b0;
    @(negedge clk);
    chk("abort_rd_issued", 0, cpu_rd[0], 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pins_low", 0, {cpu_rd[0], cpu_wr[0], cpu_wdata_oe[0]}, 0);
    chk("abort_no_rsp", 0, rsp_valid, 0);
    chk("abort_counters", 0, {txn_cnt, timeout_cnt, s_txn_cnt, s_timeout_cnt}, 0);
    chk("ready_low_in_reset", 0, cmd_ready, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet", 0, {rsp_valid, cpu_rd}, 0);
    end
    chk("ready_after_abort", 0, cmd_ready, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit ch0 got=%0d expected=%0d", cyc, 0);
    $fatal(1, "time limit");
  end

endmodule
